// File: rtl/mem_stage_lsu_if.sv
// MEM-stage bus bundle: pipeline controls, address/data, branch flags and MEM/WB outputs.
interface mem_stage_lsu_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_in;
    logic            Ctl_MemtoReg_in;
    logic            Ctl_RegWrite_in;
    logic            Ctl_MemRead_in;
    logic            Ctl_MemWrite_in;
    logic            Ctl_Branch_in;
    logic [2:0]      funct3_in;
    logic            Zero_in;
    logic            Lt_in;
    logic            Ltu_in;
    logic [4:0]      Rd_in;
    logic [XLEN-1:0] ALUresult_in;
    logic [XLEN-1:0] Write_Data;
    logic [XLEN-1:0] PCimm_in;

    logic            PCSrc;
    logic [XLEN-1:0] PCimm_out;
    logic            mem_busy;
    logic            Ctl_MemtoReg_out;
    logic            Ctl_RegWrite_out;
    logic [4:0]      Rd_out;
    logic [XLEN-1:0] ALUresult_out;
    logic [XLEN-1:0] Read_Data;
    logic            misalign_out;

    modport master (
        output stall_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
        output Ctl_Branch_in, funct3_in, Zero_in, Lt_in, Ltu_in, Rd_in,
        output ALUresult_in, Write_Data, PCimm_in,
        input  PCSrc, PCimm_out, mem_busy, Ctl_MemtoReg_out, Ctl_RegWrite_out,
        input  Rd_out, ALUresult_out, Read_Data, misalign_out
    );

    modport slave (
        input  stall_in, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
        input  Ctl_Branch_in, funct3_in, Zero_in, Lt_in, Ltu_in, Rd_in,
        input  ALUresult_in, Write_Data, PCimm_in,
        output PCSrc, PCimm_out, mem_busy, Ctl_MemtoReg_out, Ctl_RegWrite_out,
        output Rd_out, ALUresult_out, Read_Data, misalign_out
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RISC-V MEM stage: byte/half/word load-store on a word RAM, branch resolve, MEM/WB register.
// A clear sequencer zeroes the RAM after reset before accesses are honoured.
module mem_stage_lsu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256
) (
    input logic            clk,
    input logic            reset,
    mem_stage_lsu_if.slave bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LANES = XLEN / 8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            busy;

    logic [XLEN-1:0] mem_q [DEPTH];

    logic            memtoreg_q, regwrite_q, misalign_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alu_q, rdata_q;

    logic [1:0]       lane;
    logic [AW-1:0]    widx;
    logic             run;
    logic             is_byte, is_half, is_word, size_ok, bad_align, misalign;
    logic             store_en;
    logic [LANES-1:0] be;
    logic [XLEN-1:0]  wdata;
    logic [XLEN-1:0]  rd_word, ld_ext;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic             sext;
    logic             br_cond;

    // Clear sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: ;
            default: state_d = ST_CLEAR;
        endcase
    end

    assign run  = (state_q == ST_RUN);
    assign lane = bus.ALUresult_in[1:0];
    assign widx = bus.ALUresult_in[AW+1:2];

    // Size decode; unsigned codes are load-only, so a store with them is rejected
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        size_ok = 1'b1;
        case (bus.funct3_in)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            3'b010:         is_word = 1'b1;
            default:        size_ok = 1'b0;
        endcase
        bad_align = (is_half & lane[0]) | (is_word & (lane != 2'b00));
        misalign  = (bus.Ctl_MemRead_in  & (~size_ok | bad_align)) |
                    (bus.Ctl_MemWrite_in & (~size_ok | bus.funct3_in[2] | bad_align));
    end

    // Store lane enables with the data replicated across lanes
    always_comb begin
        be    = '0;
        wdata = bus.Write_Data;
        if (is_byte) begin
            be[lane] = 1'b1;
            wdata    = {LANES{bus.Write_Data[7:0]}};
        end else if (is_half) begin
            be[{lane[1], 1'b0}] = 1'b1;
            be[{lane[1], 1'b1}] = 1'b1;
            wdata               = {(LANES / 2){bus.Write_Data[15:0]}};
        end else if (is_word) begin
            be = '1;
        end
    end

    assign store_en = run & bus.Ctl_MemWrite_in & ~misalign & ~bus.stall_in & ~reset;

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (store_en) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Lane select and extension of the pre-write word
    assign rd_word = mem_q[widx];
    assign sext    = ~bus.funct3_in[2];

    always_comb begin
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = rd_word[{lane[1], 4'b0000} +: 16];
        ld_ext  = rd_word;
        if (is_byte)      ld_ext = {{(XLEN - 8){sext & ld_byte[7]}}, ld_byte};
        else if (is_half) ld_ext = {{(XLEN - 16){sext & ld_half[15]}}, ld_half};
    end

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (reset) begin
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (!bus.stall_in) begin
            memtoreg_q <= bus.Ctl_MemtoReg_in;
            regwrite_q <= bus.Ctl_RegWrite_in;
            rd_q       <= bus.Rd_in;
            alu_q      <= bus.ALUresult_in;
            misalign_q <= run & misalign;
            if (bus.Ctl_MemRead_in) rdata_q <= (run && !misalign) ? ld_ext : '0;
        end
    end

    always_comb begin
        br_cond = 1'b0;
        case (bus.funct3_in)
            3'b000:  br_cond = bus.Zero_in;
            3'b001:  br_cond = ~bus.Zero_in;
            3'b100:  br_cond = bus.Lt_in;
            3'b101:  br_cond = ~bus.Lt_in;
            3'b110:  br_cond = bus.Ltu_in;
            3'b111:  br_cond = ~bus.Ltu_in;
            default: br_cond = 1'b0;
        endcase
    end

    assign bus.PCSrc            = bus.Ctl_Branch_in & br_cond;
    assign bus.PCimm_out        = bus.PCimm_in;
    assign bus.mem_busy         = busy;
    assign bus.Ctl_MemtoReg_out = memtoreg_q;
    assign bus.Ctl_RegWrite_out = regwrite_q;
    assign bus.Rd_out           = rd_q;
    assign bus.ALUresult_out    = alu_q;
    assign bus.Read_Data        = rdata_q;
    assign bus.misalign_out     = misalign_q;
endmodule
